riscv_trace_arb: RTL and testbench

- Shares one trace sink between the two cores of the dual-core build.
- Each core's retire stream (valid, pc, opcode) is buffered in its own small FIFO.
- A round-robin scheduler drains both FIFOs into one registered valid/ready output stream, tagged with core ID and a per-core sequence number.
- Overflow entries are dropped and counted, so a retiring core is never stalled. Sits between the cores' writeback trace taps and the trace logger/monitor.

---
 rtl/riscv_trace_arb.sv | 126 ++++++++++++
 tb/tb_riscv_trace_arb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_trace_arb.sv
// Dual-core retire trace arbiter: each core's retire stream is buffered in its own FIFO
// and drained round-robin into one registered valid/ready stream tagged with core ID and sequence number.
module riscv_trace_arb #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic              core0_valid_i,
  input  logic [31:0]       core0_pc_i,
  input  logic [31:0]       core0_opcode_i,
  input  logic              core1_valid_i,
  input  logic [31:0]       core1_pc_i,
  input  logic [31:0]       core1_opcode_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_core_o,
  output logic [7:0]        out_seq_o,
  output logic [31:0]       out_pc_o,
  output logic [31:0]       out_opcode_o,
  output logic [DROP_W-1:0] drop0_o,
  output logic [DROP_W-1:0] drop1_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [7:0]  seq;
    logic [31:0] pc;
    logic [31:0] opcode;
  } entry_t;

  logic [1:0]              in_valid;
  logic [1:0][31:0]        in_pc;
  logic [1:0][31:0]        in_opcode;
  logic [1:0]              empty;
  logic [1:0]              full;
  logic [1:0]              capture;
  logic [1:0]              push;
  logic [1:0]              pop;
  entry_t [1:0]            head;
  logic [1:0][DROP_W-1:0]  drop_cnt;
  logic                    last_grant;
  logic                    grant;
  logic                    load;

  assign in_valid  = {core1_valid_i, core0_valid_i};
  assign in_pc     = {core1_pc_i, core0_pc_i};
  assign in_opcode = {core1_opcode_i, core0_opcode_i};

  for (genvar n = 0; n < 2; n++) begin : g_core
    entry_t          mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [7:0]      seq_q;
    logic [DROP_W-1:0] drop_q;

    assign empty[n]   = (wr_ptr == rd_ptr);
    assign full[n]    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign capture[n] = enable_i && in_valid[n];
    // Full is judged on pre-edge occupancy, so a pop in the same cycle does not make room.
    assign push[n]    = capture[n] && !full[n];
    assign head[n]    = mem[rd_ptr[AW-1:0]];
    assign drop_cnt[n] = drop_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        seq_q  <= '0;
        drop_q <= '0;
      end else if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        seq_q  <= '0;
        drop_q <= '0;
      end else begin
        if (push[n]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[n]) rd_ptr <= rd_ptr + 1'b1;
        if (capture[n]) seq_q <= seq_q + 8'd1;
        if (capture[n] && full[n] && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (push[n] && !flush_i) mem[wr_ptr[AW-1:0]] <= entry_t'{seq_q, in_pc[n], in_opcode[n]};
    end
  end

  always_comb begin
    load = (!out_valid_o || out_ready_i) && (empty != 2'b11);
    if (!empty[0] && !empty[1]) grant = ~last_grant;
    else grant = empty[0];
    pop = '0;
    if (load) pop = grant ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_o  <= 1'b0;
      out_core_o   <= 1'b0;
      out_seq_o    <= '0;
      out_pc_o     <= '0;
      out_opcode_o <= '0;
      last_grant   <= 1'b1;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
      last_grant  <= 1'b1;
    end else if (load) begin
      out_valid_o  <= 1'b1;
      out_core_o   <= grant;
      out_seq_o    <= head[grant].seq;
      out_pc_o     <= head[grant].pc;
      out_opcode_o <= head[grant].opcode;
      last_grant   <= grant;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  assign drop0_o = drop_cnt[0];
  assign drop1_o = drop_cnt[1];

endmodule

// File: tb/tb_riscv_trace_arb.sv
// Self-checking bench for riscv_trace_arb: table-driven round-robin vectors,
// hand-written corner sequences, and a scoreboard checked on every output handshake.
module tb_riscv_trace_arb;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        enable_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        c0v = 1'b0, c1v = 1'b0;
  logic [31:0] c0pc = '0, c0op = '0, c1pc = '0, c1op = '0;
  logic        ready = 1'b0;

  logic        out_valid, out_core;
  logic [7:0]  out_seq;
  logic [31:0] out_pc, out_op;
  logic [15:0] drop0, drop1;

  logic        v4, core4;
  logic [7:0]  seq4;
  logic [31:0] pc4, op4;
  logic [3:0]  d0_4, d1_4;

  always #5 clk = ~clk;

  riscv_trace_arb dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
    .core0_valid_i(c0v), .core0_pc_i(c0pc), .core0_opcode_i(c0op),
    .core1_valid_i(c1v), .core1_pc_i(c1pc), .core1_opcode_i(c1op),
    .out_valid_o(out_valid), .out_ready_i(ready), .out_core_o(out_core),
    .out_seq_o(out_seq), .out_pc_o(out_pc), .out_opcode_o(out_op),
    .drop0_o(drop0), .drop1_o(drop1)
  );

  riscv_trace_arb #(.DEPTH(4), .DROP_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
    .core0_valid_i(c0v), .core0_pc_i(c0pc), .core0_opcode_i(c0op),
    .core1_valid_i(c1v), .core1_pc_i(c1pc), .core1_opcode_i(c1op),
    .out_valid_o(v4), .out_ready_i(ready), .out_core_o(core4),
    .out_seq_o(seq4), .out_pc_o(pc4), .out_opcode_o(op4),
    .drop0_o(d0_4), .drop1_o(d1_4)
  );

  typedef struct packed {
    logic        core;
    logic [7:0]  seq;
    logic [31:0] pc;
    logic [31:0] op;
  } exp_t;

  typedef struct {
    bit          v;
    logic [31:0] pc0;
    logic [31:0] pc1;
    bit          ev;
    bit          ecore;
    logic [7:0]  eseq;
    logic [31:0] epc;
  } vec_t;

  exp_t sb[$];
  exp_t held;
  logic hold_q = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] f_op(input logic [31:0] pc);
    return pc + 32'h13;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Handshake monitor and hold-stability check, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t cur, e;
    cur = '{out_core, out_seq, out_pc, out_op};
    if (!rst_i) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q && out_valid) chk("hold_stable", cur, held);
      hold_q = out_valid && !ready && !flush_i;
      held = cur;
      if (out_valid && ready && !flush_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%0h expected=none", cur);
        end else begin
          e = sb.pop_front();
          chk("out_entry", cur, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input int max_cycles);
    ready = 1'b1;
    c0v = 1'b0;
    c1v = 1'b0;
    for (int i = 0; i < max_cycles && (sb.size() != 0 || out_valid); i++) tick();
    checks++;
    if (sb.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout actual_left=%0d expected_left=0", sb.size());
    end
  endtask

  task automatic cap0(input logic [31:0] pc, input bit expect_out, input logic [7:0] seq);
    c0v = 1'b1;
    c0pc = pc;
    c0op = f_op(pc);
    if (expect_out) sb.push_back('{1'b0, seq, pc, f_op(pc)});
  endtask

  task automatic cap1(input logic [31:0] pc, input bit expect_out, input logic [7:0] seq);
    c1v = 1'b1;
    c1pc = pc;
    c1op = f_op(pc);
    if (expect_out) sb.push_back('{1'b1, seq, pc, f_op(pc)});
  endtask

  vec_t rr[10];

  initial begin
    rr[0] = '{1, 32'h100, 32'h200, 0, 0, 8'd0, 32'h0};
    rr[1] = '{1, 32'h104, 32'h204, 1, 0, 8'd0, 32'h100};
    rr[2] = '{1, 32'h108, 32'h208, 1, 1, 8'd0, 32'h200};
    rr[3] = '{1, 32'h10C, 32'h20C, 1, 0, 8'd1, 32'h104};
    rr[4] = '{0, 32'h0,   32'h0,   1, 1, 8'd1, 32'h204};
    rr[5] = '{0, 32'h0,   32'h0,   1, 0, 8'd2, 32'h108};
    rr[6] = '{0, 32'h0,   32'h0,   1, 1, 8'd2, 32'h208};
    rr[7] = '{0, 32'h0,   32'h0,   1, 0, 8'd3, 32'h10C};
    rr[8] = '{0, 32'h0,   32'h0,   1, 1, 8'd3, 32'h20C};
    rr[9] = '{0, 32'h0,   32'h0,   0, 0, 8'd0, 32'h0};

    // Reset state
    #2;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_fields", {out_core, out_seq, out_pc, out_op}, '0);
    chk("rst_drops", {drop0, drop1}, '0);
    #10 rst_i = 1'b1;

    // Single entry latency
    ready = 1'b1;
    c0v = 1'b1;
    c0pc = 32'h8000_0000;
    c0op = 32'h0000_0013;
    sb.push_back('{1'b0, 8'd0, 32'h8000_0000, 32'h0000_0013});
    tick();
    c0v = 1'b0;
    chk("single_e0_valid", out_valid, 1'b0);
    tick();
    chk("single_e1_valid", out_valid, 1'b1);
    chk("single_e1_data", {out_core, out_seq, out_pc, out_op}, {1'b0, 8'd0, 32'h8000_0000, 32'h13});
    tick();
    chk("single_e2_valid", out_valid, 1'b0);

    // Round-robin table
    do_flush();
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      c0v = rr[i].v;
      c1v = rr[i].v;
      if (rr[i].v) begin
        cap0(rr[i].pc0, 1'b1, 8'(i));
        cap1(rr[i].pc1, 1'b1, 8'(i));
      end
      tick();
      chk("rr_valid", out_valid, rr[i].ev);
      if (rr[i].ev) chk("rr_entry", {out_core, out_seq, out_pc}, {rr[i].ecore, rr[i].eseq, rr[i].epc});
    end
    c0v = 1'b0;
    c1v = 1'b0;
    drain(10);

    // Backpressure: seq 0 held in output, 1-4 buffered, 5 dropped
    do_flush();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cap0(32'h1000 + 32'(4 * i), i < 5, 8'(i));
      tick();
    end
    c0v = 1'b0;
    chk("bp_drop0", drop0, 16'd1);
    chk("bp_head", {out_valid, out_seq}, {1'b1, 8'd0});
    drain(20);

    // Full FIFO with simultaneous pop: incoming entry still dropped
    do_flush();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cap0(32'h2000 + 32'(4 * i), 1'b1, 8'(i));
      tick();
    end
    chk("fp_no_drop_yet", drop0, 16'd0);
    ready = 1'b1;
    cap0(32'h2014, 1'b0, 8'd5);
    tick();
    c0v = 1'b0;
    chk("fp_drop0", drop0, 16'd1);
    chk("fp_popped", {out_valid, out_seq}, {1'b1, 8'd1});
    drain(20);

    // Saturation of the narrow counter and 8-bit seq wrap
    do_flush();
    ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cap1(32'h4000 + 32'(4 * i), i < 5, 8'(i));
      tick();
    end
    c1v = 1'b0;
    chk("sat_drop1_wide", drop1, 16'd295);
    chk("sat_drop1_narrow", d1_4, 4'hF);
    chk("sat_drop0_narrow", d0_4, 4'h0);
    chk("sat_narrow_out", {v4, core4, seq4, pc4, op4}, {1'b1, 1'b1, 8'd0, 32'h4000, f_op(32'h4000)});
    drain(20);
    cap1(32'h5000, 1'b1, 8'd44);
    tick();
    c1v = 1'b0;
    drain(10);

    // Flush with concurrent capture, then enable gating
    do_flush();
    ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cap0(32'h3000 + 32'(4 * i), 1'b0, 8'(i));
      tick();
    end
    chk("fl_pre_drop0", drop0, 16'd2);
    flush_i = 1'b1;
    cap0(32'h3F00, 1'b0, 8'd7);
    tick();
    flush_i = 1'b0;
    c0v = 1'b0;
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_drops", {drop0, drop1}, '0);
    ready = 1'b1;
    cap0(32'h3000, 1'b1, 8'd0);
    tick();
    enable_i = 1'b0;
    cap0(32'h3100, 1'b0, 8'd1);
    tick();
    tick();
    c0v = 1'b0;
    enable_i = 1'b1;
    chk("en_no_drop", drop0, 16'd0);
    cap0(32'h3200, 1'b1, 8'd1);
    tick();
    c0v = 1'b0;
    drain(10);

    // Asynchronous reset while an entry is held
    ready = 1'b0;
    cap1(32'h6000, 1'b0, 8'd0);
    tick();
    c1v = 1'b0;
    tick();
    chk("ar_pre_valid", out_valid, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    chk("ar_valid_now", out_valid, 1'b0);
    #3 rst_i = 1'b1;
    sb.delete();
    ready = 1'b1;
    tick();
    tick();
    chk("ar_post_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
